mem_fill: RTL and testbench
===========================

MEM_FILL -- requirements
Module: mem_fill

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16, width of one memory word.
REQ-002 SHALL have parameter MEM_SIZE, default 16, memory address width.
REQ-003 SHALL have parameter LANES, default 4, words written per beat; power of two, 1..8.
REQ-004 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  in  1  start request, sampled only in IDLE.
REQ-007 SHALL have port abort  in  1  terminate an active fill.
REQ-008 SHALL have port base  in  MEM_SIZE  first word address.
REQ-009 SHALL have port len  in  MEM_SIZE+1  number of words to write.
REQ-010 SHALL have port mode  in  2  0 = zero, 1 = constant, 2 = incrementing, 3 = treated as 0.
REQ-011 SHALL have port fill_val  in  DATA_SIZE  constant value / incrementing seed.
REQ-012 SHALL have port wr_rdy  in  1  memory accepts the current beat.
REQ-013 SHALL have port wr_we  out  1  write beat valid.
REQ-014 SHALL have port wr_wa  out  MEM_SIZE  address of lane 0.
REQ-015 SHALL have port wr_wd  out  LANES*DATA_SIZE  lane k in bits [k*DATA_SIZE +: DATA_SIZE].
REQ-016 SHALL have port wr_mask  out  LANES  per-lane write enable.
REQ-017 SHALL have port done  out  1  level; high whenever no fill is active.
REQ-018 SHALL have port done_p  out  1  one-cycle pulse on normal completion.
REQ-019 SHALL have port aborted  out  1  last fill ended by abort; cleared on next accepted en.

Function
REQ-020 SHALL implement two states: IDLE and FILL.
REQ-021 SHALL, in IDLE with en=1 and len!=0: capture base, len, mode and fill_val; set done=0, wr_we=1, wr_wa=base, aborted=0; enter FILL. All outputs registered.
REQ-022 SHALL, in IDLE with en=1 and len=0: issue no beat, keep done=1, assert done_p the next cycle, clear aborted.
REQ-023 SHALL count a beat as accepted only when wr_we=1 and wr_rdy=1.
REQ-024 SHALL hold wr_wa, wr_wd and wr_mask stable while wr_we=1 and wr_rdy=0.
REQ-025 SHALL, per accepted beat, advance wr_wa by LANES modulo 2^MEM_SIZE and decrease the remaining count by LANES.
REQ-026 SHALL set wr_mask bit k = 1 iff k < min(LANES, remaining); only the final beat is partial.
REQ-027 SHALL drive lane k data: mode 0 -> 0; mode 1 -> fill_val; mode 2 -> fill_val + (words already accepted) + k, truncated to DATA_SIZE; masked lanes drive 0.
REQ-028 SHALL, on acceptance of the final beat: next cycle wr_we=0, done=1, done_p=1 for exactly one cycle, wr_wa=0; return to IDLE.
REQ-029 SHALL, on abort=1 in FILL without final acceptance: next cycle wr_we=0, done=1, aborted=1, wr_wa=0, no done_p; an accepted beat in that same cycle counts as written.
REQ-030 SHALL let completion win when abort coincides with final-beat acceptance: done_p=1, aborted=0.
REQ-031 SHALL ignore en while in FILL and ignore abort while in IDLE.
REQ-032 SHALL, with wr_rdy held high, write len words in ceil(len/LANES) consecutive cycles with done_p in the cycle after the last beat.

Reset
REQ-033 SHALL, on rst, immediately set IDLE, done=1, done_p=0, aborted=0, wr_we=0, wr_wa=0, wr_mask=0, wr_wd=0 and remaining count=0, including mid-fill.

Verification (LANES=4, DATA_SIZE=16, MEM_SIZE=16)
REQ-034 SHALL cover reset during FILL -> wr_we=0, done=1, wr_wa=0 with no clock edge; a subsequent en starts cleanly.
REQ-035 SHALL cover base=0x0100, len=10, mode 0, wr_rdy=1, en at edge 0 -> beats at 0x0100/0x0104/0x0108, masks 1111/1111/0011, data 0, then done_p=1 and done=1.
REQ-036 SHALL cover mode 2, fill_val=0xFFFE, len=4 -> one beat with lanes 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-037 SHALL cover len=12 with wr_rdy low for 2 cycles during beat 2 -> beat 2 held unchanged, 3 accepted beats total, done_p once.
REQ-038 SHALL cover abort asserted during beat 2 of len=16 with wr_rdy=0 -> wr_we=0 next cycle, aborted=1, done=1, done_p never asserted.
REQ-039 SHALL cover base=0xFFFE, len=8 -> wr_wa 0xFFFE then 0x0002; and len=0 -> no wr_we, done_p for one cycle.

Source files
------------

// File: rtl/mem_fill_if.sv
// mem_fill write-port bundle: one multi-lane beat per wr_we/wr_rdy handshake.
// Ports: wr_we, wr_wa, wr_wd, wr_mask (fill -> memory); wr_rdy (memory -> fill).
interface mem_fill_if #(
   parameter int DATA_SIZE = 16,
   parameter int MEM_SIZE  = 16,
   parameter int LANES     = 4
);
   logic                       wr_we;
   logic [MEM_SIZE-1:0]        wr_wa;
   logic [LANES*DATA_SIZE-1:0] wr_wd;
   logic [LANES-1:0]           wr_mask;
   logic                       wr_rdy;

   modport master (
      output wr_we, wr_wa, wr_wd, wr_mask,
      input  wr_rdy
   );

   modport slave (
      input  wr_we, wr_wa, wr_wd, wr_mask,
      output wr_rdy
   );
endinterface

// File: rtl/mem_fill.sv
// Memory fill engine: writes len words from base, LANES words per beat.
// Ports: clk, rst, en, abort, base, len, mode, fill_val, wr (master), done, done_p, aborted.
module mem_fill #(
   parameter int DATA_SIZE = 16,
   parameter int MEM_SIZE  = 16,
   parameter int LANES     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 abort,
   input  logic [MEM_SIZE-1:0]  base,
   input  logic [MEM_SIZE:0]    len,
   input  logic [1:0]           mode,
   input  logic [DATA_SIZE-1:0] fill_val,
   mem_fill_if.master           wr,
   output logic                 done,
   output logic                 done_p,
   output logic                 aborted
);

   typedef enum logic {S_IDLE, S_FILL} t_state;

   localparam int DW = LANES * DATA_SIZE;

   t_state               r_state, w_state;
   logic [MEM_SIZE:0]    r_rem, w_rem;
   logic [DATA_SIZE-1:0] r_acc, w_acc;
   logic [1:0]           r_mode, w_mode;
   logic [DATA_SIZE-1:0] r_val, w_val;
   logic                 r_we, w_we;
   logic [MEM_SIZE-1:0]  r_wa, w_wa;
   logic [DW-1:0]        r_wd, w_wd;
   logic [LANES-1:0]     r_mask, w_mask;
   logic                 r_done, w_done;
   logic                 r_done_p, w_done_p;
   logic                 r_aborted, w_aborted;

   logic                 w_take;
   logic                 w_last;
   logic [MEM_SIZE:0]    w_rem_nx;
   logic [DATA_SIZE-1:0] w_acc_nx;
   logic [LANES-1:0]     w_mask_nx;

   // Lane k is live while more than k words remain.
   function automatic logic [LANES-1:0] f_mask(
      input logic [MEM_SIZE:0] rem
   );
      logic [LANES-1:0] m;
      m = '0;
      for (int k = 0; k < LANES; k++)
         m[k] = (rem > (MEM_SIZE+1)'(k));
      return m;
   endfunction

   // acc is the count of words already accepted (mod 2^DATA_SIZE).
   function automatic logic [DW-1:0] f_data(
      input logic [1:0]           md,
      input logic [DATA_SIZE-1:0] val,
      input logic [DATA_SIZE-1:0] acc,
      input logic [LANES-1:0]     m
   );
      logic [DW-1:0] d;
      d = '0;
      for (int k = 0; k < LANES; k++) begin
         if (m[k]) begin
            case (md)
               2'd1:    d[k*DATA_SIZE +: DATA_SIZE] = val;
               2'd2:    d[k*DATA_SIZE +: DATA_SIZE] =
                           val + acc + DATA_SIZE'(k);
               default: d[k*DATA_SIZE +: DATA_SIZE] = '0;
            endcase
         end
      end
      return d;
   endfunction

   assign w_take    = r_we & wr.wr_rdy;
   assign w_last    = (r_rem <= (MEM_SIZE+1)'(LANES));
   assign w_rem_nx  = r_rem - (MEM_SIZE+1)'(LANES);
   assign w_acc_nx  = r_acc + DATA_SIZE'(LANES);
   assign w_mask_nx = f_mask(w_rem_nx);

   always_comb begin
      w_state   = r_state;
      w_rem     = r_rem;
      w_acc     = r_acc;
      w_mode    = r_mode;
      w_val     = r_val;
      w_we      = r_we;
      w_wa      = r_wa;
      w_wd      = r_wd;
      w_mask    = r_mask;
      w_done    = r_done;
      w_done_p  = 1'b0;
      w_aborted = r_aborted;
      case (r_state)
         S_IDLE: begin
            if (en) begin
               w_aborted = 1'b0;
               if (len != '0) begin
                  w_state = S_FILL;
                  w_rem   = len;
                  w_acc   = '0;
                  w_mode  = mode;
                  w_val   = fill_val;
                  w_we    = 1'b1;
                  w_wa    = base;
                  w_mask  = f_mask(len);
                  w_wd    = f_data(mode, fill_val,
                                   '0, f_mask(len));
                  w_done  = 1'b0;
               end else begin
                  w_done_p = 1'b1;
               end
            end
         end
         S_FILL: begin
            // Completion takes priority over a coincident abort.
            if (w_take && w_last) begin
               w_state  = S_IDLE;
               w_rem    = '0;
               w_we     = 1'b0;
               w_wa     = '0;
               w_wd     = '0;
               w_mask   = '0;
               w_done   = 1'b1;
               w_done_p = 1'b1;
            end else if (abort) begin
               w_state   = S_IDLE;
               w_rem     = '0;
               w_we      = 1'b0;
               w_wa      = '0;
               w_wd      = '0;
               w_mask    = '0;
               w_done    = 1'b1;
               w_aborted = 1'b1;
            end else if (w_take) begin
               w_rem  = w_rem_nx;
               w_acc  = w_acc_nx;
               w_wa   = r_wa + MEM_SIZE'(LANES);
               w_mask = w_mask_nx;
               w_wd   = f_data(r_mode, r_val,
                               w_acc_nx, w_mask_nx);
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_rem     <= '0;
         r_acc     <= '0;
         r_mode    <= '0;
         r_val     <= '0;
         r_we      <= 1'b0;
         r_wa      <= '0;
         r_wd      <= '0;
         r_mask    <= '0;
         r_done    <= 1'b1;
         r_done_p  <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_rem     <= w_rem;
         r_acc     <= w_acc;
         r_mode    <= w_mode;
         r_val     <= w_val;
         r_we      <= w_we;
         r_wa      <= w_wa;
         r_wd      <= w_wd;
         r_mask    <= w_mask;
         r_done    <= w_done;
         r_done_p  <= w_done_p;
         r_aborted <= w_aborted;
      end
   end

   assign wr.wr_we   = r_we;
   assign wr.wr_wa   = r_wa;
   assign wr.wr_wd   = r_wd;
   assign wr.wr_mask = r_mask;
   assign done       = r_done;
   assign done_p     = r_done_p;
   assign aborted    = r_aborted;

endmodule

// File: tb/tb_mem_fill.sv
// Bench for mem_fill: directed fills against a beat-list model.
// No ports; drives the DUT through mem_fill_if and checks every cycle.
module tb_mem_fill;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        abort;
   logic [15:0] base;
   logic [16:0] len;
   logic [1:0]  mode;
   logic [15:0] fill_val;
   logic        done;
   logic        done_p;
   logic        aborted;

   mem_fill_if #(.DATA_SIZE(16), .MEM_SIZE(16), .LANES(4)) wr_if ();

   mem_fill #(.DATA_SIZE(16), .MEM_SIZE(16), .LANES(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .abort    (abort),
      .base     (base),
      .len      (len),
      .mode     (mode),
      .fill_val (fill_val),
      .wr       (wr_if),
      .done     (done),
      .done_p   (done_p),
      .aborted  (aborted)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Expected beat list; tb appends, compare process consumes.
   logic [15:0] exp_addr [0:511];
   logic [3:0]  exp_mask [0:511];
   logic [63:0] exp_data [0:511];
   int exp_n  = 0;
   int rd_idx = 0;
   int dp_tot = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Beat i covers words 4i..4i+3 of the fill.
   task automatic push_fill(input logic [15:0] b, input int l,
                            input logic [1:0] m, input logic [15:0] v);
      int nb;
      int n;
      logic [63:0] d;
      nb = (l + 3) / 4;
      for (int i = 0; i < nb; i++) begin
         n = l - 4 * i;
         if (n > 4) n = 4;
         d = '0;
         for (int k = 0; k < n; k++) begin
            if (m == 2'd1)
               d[k*16 +: 16] = v;
            else if (m == 2'd2)
               d[k*16 +: 16] = v + 16'(4 * i + k);
         end
         exp_addr[exp_n] = b + 16'(4 * i);
         exp_mask[exp_n] = 4'((1 << n) - 1);
         exp_data[exp_n] = d;
         exp_n++;
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("inv_done", {63'd0, done}, {63'd0, ~wr_if.wr_we});
         chk("inv_dp_done", {63'd0, done_p & ~done}, 64'd0);
         if (done_p) dp_tot++;
         if (wr_if.wr_we) begin
            if (rd_idx >= exp_n) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: got wa %0h expected no beat",
                        wr_if.wr_wa);
            end else begin
               chk("beat_wa", {48'd0, wr_if.wr_wa},
                   {48'd0, exp_addr[rd_idx]});
               chk("beat_mask", {60'd0, wr_if.wr_mask},
                   {60'd0, exp_mask[rd_idx]});
               chk("beat_wd", wr_if.wr_wd, exp_data[rd_idx]);
               if (wr_if.wr_rdy) rd_idx++;
            end
         end else begin
            chk("idle_wa", {48'd0, wr_if.wr_wa}, 64'd0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [15:0] b, input int l,
                        input logic [1:0] m, input logic [15:0] v);
      base     = b;
      len      = 17'(l);
      mode     = m;
      fill_val = v;
      en       = 1'b1;
      push_fill(b, l, m, v);
      step();
      en = 1'b0;
   endtask

   task automatic run_to_done(input int max);
      int c;
      c = 0;
      while (!done && c < max) begin
         step();
         c++;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL timeout: got done=0 after %0d cycles expected done=1",
                  c);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   int a0, d0, e0;

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      abort    = 1'b0;
      base     = '0;
      len      = '0;
      mode     = '0;
      fill_val = '0;
      wr_if.wr_rdy = 1'b0;
      #2;
      chk("rst_we", {63'd0, wr_if.wr_we}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd1);
      chk("rst_dp", {63'd0, done_p}, 64'd0);
      chk("rst_ab", {63'd0, aborted}, 64'd0);
      chk("rst_wa", {48'd0, wr_if.wr_wa}, 64'd0);
      chk("rst_mask", {60'd0, wr_if.wr_mask}, 64'd0);
      chk("rst_wd", wr_if.wr_wd, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // base 0x100, len 10, zero fill
      wr_if.wr_rdy = 1'b1;
      a0 = rd_idx; e0 = exp_n;
      start(16'h0100, 10, 2'd0, 16'h1234);
      chk("m_pin_wa2", {48'd0, exp_addr[e0+2]}, 64'h108);
      chk("m_pin_mk2", {60'd0, exp_mask[e0+2]}, 64'h3);
      chk("t35_wa0", {48'd0, wr_if.wr_wa}, 64'h100);
      chk("t35_mk0", {60'd0, wr_if.wr_mask}, 64'hF);
      chk("t35_wd0", wr_if.wr_wd, 64'd0);
      chk("t35_dn0", {63'd0, done}, 64'd0);
      step();
      chk("t35_wa1", {48'd0, wr_if.wr_wa}, 64'h104);
      step();
      chk("t35_wa2", {48'd0, wr_if.wr_wa}, 64'h108);
      chk("t35_mk2", {60'd0, wr_if.wr_mask}, 64'h3);
      step();
      chk("t35_dp", {63'd0, done_p}, 64'd1);
      chk("t35_done", {63'd0, done}, 64'd1);
      chk("t35_we", {63'd0, wr_if.wr_we}, 64'd0);
      step();
      chk("t35_dp_off", {63'd0, done_p}, 64'd0);
      chk("t35_beats", 64'(rd_idx - a0), 64'd3);

      // incrementing wrap
      e0 = exp_n;
      start(16'h0200, 4, 2'd2, 16'hFFFE);
      chk("m_pin_wd", exp_data[e0], 64'h0001_0000_FFFF_FFFE);
      chk("t36_wd", wr_if.wr_wd, 64'h0001_0000_FFFF_FFFE);
      step();
      chk("t36_dp", {63'd0, done_p}, 64'd1);
      step();

      start(16'h0300, 7, 2'd2, 16'h0010);
      step();
      chk("inc_wd1", wr_if.wr_wd, 64'h0000_0016_0015_0014);
      chk("inc_mk1", {60'd0, wr_if.wr_mask}, 64'h7);
      step();
      chk("inc_dp", {63'd0, done_p}, 64'd1);
      step();

      start(16'h0400, 5, 2'd1, 16'hA5A5);
      chk("cst_wd0", wr_if.wr_wd, 64'hA5A5_A5A5_A5A5_A5A5);
      step();
      chk("cst_mk1", {60'd0, wr_if.wr_mask}, 64'h1);
      chk("cst_wd1", wr_if.wr_wd, 64'h0000_0000_0000_A5A5);
      step();
      chk("cst_dp", {63'd0, done_p}, 64'd1);
      step();

      start(16'h0500, 3, 2'd3, 16'h7777);
      chk("m3_wd", wr_if.wr_wd, 64'd0);
      chk("m3_mk", {60'd0, wr_if.wr_mask}, 64'h7);
      step();
      step();

      // stall during beat 2
      a0 = rd_idx; d0 = dp_tot;
      start(16'h0600, 12, 2'd2, 16'h0000);
      step();
      wr_if.wr_rdy = 1'b0;
      step();
      chk("t37_wa_h1", {48'd0, wr_if.wr_wa}, 64'h604);
      chk("t37_wd_h1", wr_if.wr_wd, 64'h0007_0006_0005_0004);
      chk("t37_mk_h1", {60'd0, wr_if.wr_mask}, 64'hF);
      step();
      chk("t37_wa_h2", {48'd0, wr_if.wr_wa}, 64'h604);
      chk("t37_wd_h2", wr_if.wr_wd, 64'h0007_0006_0005_0004);
      wr_if.wr_rdy = 1'b1;
      run_to_done(10);
      chk("t37_dp", {63'd0, done_p}, 64'd1);
      step();
      chk("t37_beats", 64'(rd_idx - a0), 64'd3);
      chk("t37_dp_cnt", 64'(dp_tot - d0), 64'd1);

      // abort while stalled
      a0 = rd_idx; d0 = dp_tot;
      start(16'h0700, 16, 2'd0, 16'h0000);
      step();
      wr_if.wr_rdy = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      exp_n = rd_idx;
      chk("t38_we", {63'd0, wr_if.wr_we}, 64'd0);
      chk("t38_ab", {63'd0, aborted}, 64'd1);
      chk("t38_done", {63'd0, done}, 64'd1);
      chk("t38_wa", {48'd0, wr_if.wr_wa}, 64'd0);
      repeat (3) step();
      chk("t38_beats", 64'(rd_idx - a0), 64'd1);
      chk("t38_dp_cnt", 64'(dp_tot - d0), 64'd0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("idle_abort_ab", {63'd0, aborted}, 64'd1);
      chk("idle_abort_dn", {63'd0, done}, 64'd1);

      // abort together with final acceptance
      wr_if.wr_rdy = 1'b1;
      start(16'h0800, 4, 2'd1, 16'h0042);
      chk("ab_clr", {63'd0, aborted}, 64'd0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t30_dp", {63'd0, done_p}, 64'd1);
      chk("t30_ab", {63'd0, aborted}, 64'd0);
      step();

      // abort together with a non-final acceptance
      a0 = rd_idx;
      start(16'h0900, 8, 2'd2, 16'h0100);
      abort = 1'b1;
      step();
      abort = 1'b0;
      exp_n = rd_idx;
      chk("t29_ab", {63'd0, aborted}, 64'd1);
      chk("t29_beats", 64'(rd_idx - a0), 64'd1);

      // len 0
      base = 16'h1234;
      len  = '0;
      en   = 1'b1;
      step();
      en = 1'b0;
      chk("l0_we", {63'd0, wr_if.wr_we}, 64'd0);
      chk("l0_done", {63'd0, done}, 64'd1);
      chk("l0_dp", {63'd0, done_p}, 64'd1);
      chk("l0_ab", {63'd0, aborted}, 64'd0);
      step();
      chk("l0_dp_off", {63'd0, done_p}, 64'd0);

      // address wrap
      start(16'hFFFE, 8, 2'd2, 16'h0000);
      chk("t39_wa0", {48'd0, wr_if.wr_wa}, 64'hFFFE);
      step();
      chk("t39_wa1", {48'd0, wr_if.wr_wa}, 64'h0002);
      chk("t39_wd1", wr_if.wr_wd, 64'h0007_0006_0005_0004);
      step();
      chk("t39_dp", {63'd0, done_p}, 64'd1);
      step();

      // en ignored during fill
      a0 = rd_idx;
      start(16'h0A00, 12, 2'd1, 16'h5555);
      base = 16'hBEEF;
      len  = 17'd4;
      en   = 1'b1;
      step();
      en = 1'b0;
      run_to_done(10);
      step();
      chk("enf_beats", 64'(rd_idx - a0), 64'd3);

      // reset mid-fill
      wr_if.wr_rdy = 1'b0;
      start(16'h0C00, 16, 2'd0, 16'h0000);
      step();
      #2 rst = 1'b1;
      #1;
      chk("t34_we", {63'd0, wr_if.wr_we}, 64'd0);
      chk("t34_done", {63'd0, done}, 64'd1);
      chk("t34_wa", {48'd0, wr_if.wr_wa}, 64'd0);
      chk("t34_mk", {60'd0, wr_if.wr_mask}, 64'd0);
      exp_n = rd_idx;
      step();
      rst = 1'b0;
      wr_if.wr_rdy = 1'b1;
      a0 = rd_idx;
      start(16'h0D00, 6, 2'd2, 16'h0020);
      chk("t34_re_wa", {48'd0, wr_if.wr_wa}, 64'h0D00);
      run_to_done(10);
      chk("t34_re_dp", {63'd0, done_p}, 64'd1);
      step();
      chk("t34_re_beats", 64'(rd_idx - a0), 64'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
